// File: rtl/pass_enroll.sv
// Password enrollment controller: takes a new 4-digit BCD code, asks for it
// a second time, and on a match commits it to pass_out for the checker.
// The 7-segment digits show entry progress with the same glyphs as the checker.
//
// state   | meaning
// --------+------------------------------------------------------------
// LOCKED  | idle, waiting for an unlock pulse from the checker
// ENTER   | collecting the first copy of the new code
// CONFIRM | collecting the second copy for comparison
// DONE    | code committed, " SEt" shown until the next press
// FAILED  | copies differed, " Err" shown until the next press
module pass_enroll #(
  parameter logic [15:0] DEFAULT_PASS = 16'h1234,
  parameter int          TIMEOUT      = 250_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  digit,
  input  logic        load,
  input  logic        unlock,
  output logic [15:0] pass_out,
  output logic        pass_valid,
  output logic        busy,
  output logic [0:6]  HEX0,
  output logic [0:6]  HEX1,
  output logic [0:6]  HEX2,
  output logic [0:6]  HEX3
);

  localparam int            TW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  // Active-high abcdefg patterns; bit 0 of a [0:6] vector is segment a.
  localparam logic [0:6] G_BLANK = 7'b0000000;
  localparam logic [0:6] G_DASH  = 7'b0000001;
  localparam logic [0:6] G_S     = 7'b1011011;
  localparam logic [0:6] G_E     = 7'b1001111;
  localparam logic [0:6] G_T     = 7'b0001111;
  localparam logic [0:6] G_R     = 7'b0000101;

  typedef enum logic [2:0] {
    LOCKED,
    ENTER,
    CONFIRM,
    DONE,
    FAILED
  } state_t;

  state_t       state;
  logic [15:0]  new_code;
  // Only the three oldest confirm digits need storing; the fourth is
  // compared straight from the switches on the final press.
  logic [11:0]  conf_code;
  logic [1:0]   cnt;
  logic [TW-1:0] timer;
  logic         load_q;
  logic [0:6]   seg0, seg1, seg2, seg3;

  logic press;
  logic valid_press;

  assign press       = load && !load_q;
  assign valid_press = press && (digit <= 4'd9);

  assign HEX0 = ~seg0;
  assign HEX1 = ~seg1;
  assign HEX2 = ~seg2;
  assign HEX3 = ~seg3;

  function automatic logic [0:6] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1111110;
      4'd1:    glyph = 7'b0110000;
      4'd2:    glyph = 7'b1101101;
      4'd3:    glyph = 7'b1111001;
      4'd4:    glyph = 7'b0110011;
      4'd5:    glyph = 7'b1011011;
      4'd6:    glyph = 7'b1011111;
      4'd7:    glyph = 7'b1110000;
      4'd8:    glyph = 7'b1111111;
      4'd9:    glyph = 7'b1111011;
      default: glyph = G_BLANK;
    endcase
  endfunction

  // Enrollment sequencer: press edge detect, entry timer, code capture and display.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOCKED;
      pass_out   <= DEFAULT_PASS;
      pass_valid <= 1'b0;
      busy       <= 1'b0;
      new_code   <= '0;
      conf_code  <= '0;
      cnt        <= '0;
      timer      <= '0;
      load_q     <= 1'b0;
      seg0       <= G_BLANK;
      seg1       <= G_BLANK;
      seg2       <= G_BLANK;
      seg3       <= G_BLANK;
    end else begin
      load_q     <= load;
      pass_valid <= 1'b0;
      case (state)
        LOCKED: begin
          // A press arriving with unlock only opens entry; it is not a digit.
          if (unlock) begin
            state <= ENTER;
            busy  <= 1'b1;
            cnt   <= '0;
            timer <= '0;
            seg0  <= G_BLANK;
            seg1  <= G_BLANK;
            seg2  <= G_BLANK;
            seg3  <= G_BLANK;
          end
        end
        ENTER, CONFIRM: begin
          // A valid press beats timer expiry in the same cycle.
          if (valid_press) begin
            timer <= '0;
            seg3  <= seg2;
            seg2  <= seg1;
            seg1  <= seg0;
            seg0  <= glyph(digit);
            cnt   <= cnt + 2'd1;
            if (state == ENTER) begin
              new_code <= {new_code[11:0], digit};
              if (cnt == 2'd3) begin
                state <= CONFIRM;
                cnt   <= '0;
                seg0  <= G_DASH;
                seg1  <= G_DASH;
                seg2  <= G_DASH;
                seg3  <= G_DASH;
              end
            end else begin
              conf_code <= {conf_code[7:0], digit};
              if (cnt == 2'd3) begin
                cnt  <= '0;
                busy <= 1'b0;
                seg3 <= G_BLANK;
                if ({conf_code, digit} == new_code) begin
                  state      <= DONE;
                  pass_out   <= new_code;
                  pass_valid <= 1'b1;
                  seg2       <= G_S;
                  seg1       <= G_E;
                  seg0       <= G_T;
                end else begin
                  state <= FAILED;
                  seg2  <= G_E;
                  seg1  <= G_R;
                  seg0  <= G_R;
                end
              end
            end
          end else if (timer == T_LAST) begin
            state <= LOCKED;
            busy  <= 1'b0;
            cnt   <= '0;
            timer <= '0;
            seg0  <= G_BLANK;
            seg1  <= G_BLANK;
            seg2  <= G_BLANK;
            seg3  <= G_BLANK;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DONE, FAILED: begin
          // Any press acknowledges the result, whatever the switches show.
          if (press) begin
            state <= LOCKED;
            seg0  <= G_BLANK;
            seg1  <= G_BLANK;
            seg2  <= G_BLANK;
            seg3  <= G_BLANK;
          end
        end
        default: begin
          state <= LOCKED;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pass_enroll.sv
// Directed bench for pass_enroll with a short entry timeout.
module tb_pass_enroll;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  digit;
  logic        load;
  logic        unlock;
  logic [15:0] pass_out;
  logic        pass_valid;
  logic        busy;
  logic [0:6]  HEX0, HEX1, HEX2, HEX3;

  int n_checks = 0;
  int n_fails  = 0;
  int pv_seen  = 0;

  // Expected active-low segment values (a is the leftmost bit).
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b1111110;
  localparam logic [6:0] S_N   = 7'b0100100;
  localparam logic [6:0] E_N   = 7'b0110000;
  localparam logic [6:0] T_N   = 7'b1110000;
  localparam logic [6:0] R_N   = 7'b1111010;
  logic [6:0] dig_n [10];

  pass_enroll #(.DEFAULT_PASS(16'h1234), .TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .digit(digit), .load(load), .unlock(unlock),
    .pass_out(pass_out), .pass_valid(pass_valid), .busy(busy),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (pass_valid) pv_seen++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] d);
    digit = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_unlock();
    unlock = 1'b1;
    @(negedge clk);
    unlock = 1'b0;
  endtask

  task automatic chk_hex(input string tag, input logic [6:0] h3, input logic [6:0] h2,
                         input logic [6:0] h1, input logic [6:0] h0);
    chk({tag, ".hex3"}, HEX3, h3);
    chk({tag, ".hex2"}, HEX2, h2);
    chk({tag, ".hex1"}, HEX1, h1);
    chk({tag, ".hex0"}, HEX0, h0);
  endtask

  initial begin
    dig_n[0] = 7'b0000001; dig_n[1] = 7'b1001111; dig_n[2] = 7'b0010010;
    dig_n[3] = 7'b0000110; dig_n[4] = 7'b1001100; dig_n[5] = 7'b0100100;
    dig_n[6] = 7'b0100000; dig_n[7] = 7'b0001111; dig_n[8] = 7'b0000000;
    dig_n[9] = 7'b0000100;

    rst = 1'b1; digit = 4'd0; load = 1'b0; unlock = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    chk("rst.pass_out", pass_out, 16'h1234);
    chk("rst.pass_valid", pass_valid, 0);
    chk("rst.busy", busy, 0);
    chk_hex("rst", BLANK, BLANK, BLANK, BLANK);

    // Presses while locked do nothing.
    press(4'd5); press(4'd6);
    chk("locked.busy", busy, 0);
    chk_hex("locked", BLANK, BLANK, BLANK, BLANK);

    // Mismatched confirmation.
    do_unlock();
    chk("mm.busy_enter", busy, 1);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    chk_hex("mm.dash", DASH, DASH, DASH, DASH);
    press(4'd1); press(4'd2); press(4'd3); press(4'd5);
    chk_hex("mm.err", BLANK, E_N, R_N, R_N);
    chk("mm.pass_out", pass_out, 16'h1234);
    chk("mm.no_valid", pv_seen, 0);
    chk("mm.busy", busy, 0);
    press(4'd0);
    chk_hex("mm.ack", BLANK, BLANK, BLANK, BLANK);

    // Successful enrollment of 5678.
    do_unlock();
    press(4'd5);
    chk_hex("ok.d1", BLANK, BLANK, BLANK, dig_n[5]);
    press(4'd6);
    chk_hex("ok.d2", BLANK, BLANK, dig_n[5], dig_n[6]);
    press(4'd7); press(4'd8);
    chk_hex("ok.dash", DASH, DASH, DASH, DASH);
    chk("ok.busy_conf", busy, 1);
    press(4'd5); press(4'd6); press(4'd7);
    chk_hex("ok.conf3", DASH, dig_n[5], dig_n[6], dig_n[7]);
    digit = 4'd8; load = 1'b1;
    @(negedge clk);
    chk("ok.pass_valid", pass_valid, 1);
    chk("ok.pass_out", pass_out, 16'h5678);
    chk("ok.busy_done", busy, 0);
    chk_hex("ok.set", BLANK, S_N, E_N, T_N);
    load = 1'b0;
    @(negedge clk);
    chk("ok.pass_valid_drop", pass_valid, 0);
    chk("ok.pv_count", pv_seen, 1);
    press(4'd0);
    chk_hex("ok.ack", BLANK, BLANK, BLANK, BLANK);
    chk("ok.busy_ack", busy, 0);

    // Invalid digit ignored, held load counts once.
    do_unlock();
    press(4'd1);
    press(4'hB);
    chk_hex("inv", BLANK, BLANK, BLANK, dig_n[1]);
    digit = 4'd3; load = 1'b1;
    cyc(10);
    load = 1'b0;
    cyc(1);
    chk_hex("held", BLANK, BLANK, dig_n[1], dig_n[3]);
    press(4'd4);
    chk_hex("held.d3", BLANK, dig_n[1], dig_n[3], dig_n[4]);
    press(4'd2);
    chk_hex("held.dash", DASH, DASH, DASH, DASH);
    cyc(25);
    chk("conf_to.busy", busy, 0);
    chk_hex("conf_to", BLANK, BLANK, BLANK, BLANK);

    // Unlock and press together: press not taken as a digit.
    unlock = 1'b1; digit = 4'd7; load = 1'b1;
    @(negedge clk);
    unlock = 1'b0; load = 1'b0;
    @(negedge clk);
    chk("ulp.busy", busy, 1);
    chk_hex("ulp", BLANK, BLANK, BLANK, BLANK);
    press(4'd1); press(4'd2); press(4'd3);
    chk_hex("ulp.d3", BLANK, dig_n[1], dig_n[2], dig_n[3]);
    press(4'd4);
    chk_hex("ulp.dash", DASH, DASH, DASH, DASH);
    cyc(25);
    chk("ulp.to", busy, 0);

    // Timeout in ENTER: expiry falls 20 edges after the last press.
    do_unlock();
    press(4'd1); press(4'd2);
    cyc(18);
    chk("to.before", busy, 1);
    cyc(1);
    chk("to.busy", busy, 0);
    chk_hex("to", BLANK, BLANK, BLANK, BLANK);
    chk("to.pass_out", pass_out, 16'h5678);

    // Press landing on the expiry edge wins.
    do_unlock();
    press(4'd1); press(4'd2);
    cyc(18);
    digit = 4'd3; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("exp.busy", busy, 1);
    chk_hex("exp", BLANK, dig_n[1], dig_n[2], dig_n[3]);
    cyc(18);
    chk("exp.timer_cleared", busy, 1);

    // Reset in CONFIRM restores the default code.
    press(4'd4);
    chk_hex("rc.dash", DASH, DASH, DASH, DASH);
    press(4'd5);
    chk("rc.pass_before", pass_out, 16'h5678);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    chk("rc.pass_out", pass_out, 16'h1234);
    chk("rc.busy", busy, 0);
    chk_hex("rc", BLANK, BLANK, BLANK, BLANK);
    chk("rc.pv_total", pv_seen, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
